attn_result_streamer: RTL and testbench
=======================================

Name: attn_result_streamer

Overview:
- Drain side of pe_8x8_top.
- On the rising edge of `all_done`, captures the 512-bit `final_res` vector into a local buffer.
- Then streams the buffer out as 32 16-bit words over a valid/ready interface, in index order.
- Sits between the attention array and downstream storage or a host link, replacing bench-side parallel readout in integration.

Parameters:
- WORD_W, 16, width of one result element (fp16 bit pattern, opaque to this block).
- NUM_WORDS, 32, number of elements in `final_res`.
- IDX_W, 5, index width; must equal clog2(NUM_WORDS).

Ports:
- clk  input  1  single system clock, all logic on posedge.
- rst  input  1  asynchronous active-high reset.
- en  input  1  block enable; 0 freezes all state.
- all_done  input  1  completion level from pe_8x8_top; may stay high indefinitely.
- final_res  input  WORD_W*NUM_WORDS  result vector; word i = final_res[i*WORD_W +: WORD_W].
- out_data  output  WORD_W  current word.
- out_valid  output  1  out_data/out_index/out_last are valid.
- out_ready  input  1  sink accepts the word this cycle.
- out_index  output  IDX_W  index of the current word.
- out_last  output  1  high with index NUM_WORDS-1.
- busy  output  1  high in STREAM and DONE.
- stream_done  output  1  one-cycle pulse after the last transfer.
- overrun  output  1  sticky flag; a new all_done edge arrived while not IDLE.

Behaviour:
- Reset (async assert, sync-safe deassert):
  - State IDLE; buffer, out_data, out_index and done_q (registered all_done) are 0.
  - out_valid, out_last, busy, stream_done and overrun are 0.
- Edge detect: rise = en & all_done & ~done_q. done_q <= all_done each enabled cycle.
  - If all_done is high at reset release, the first enabled cycle counts as a rise.
- States:
  - IDLE:
    - On rise: latch final_res into the buffer, index <= 0, go to STREAM.
    - Registered outputs: at the edge where rise is sampled, out_valid=1 and out_data=word0 become visible. One-cycle capture latency.
  - STREAM:
    - out_valid=1 and busy=1.
    - Transfer = out_valid & out_ready & en.
    - On a transfer with index < NUM_WORDS-1: index+1, out_data = next buffer word.
    - On a transfer with index = NUM_WORDS-1: go to DONE, out_valid=0, out_last=0.
    - Without a transfer, out_data, out_index and out_last are held stable.
  - DONE:
    - stream_done=1 and busy=1 for exactly one enabled cycle, then IDLE.
- Rate: back-to-back transfers give 1 word/cycle. The full stream takes NUM_WORDS cycles from the first out_valid with out_ready held high.
- A rise while in STREAM or DONE:
  - Is ignored, with no re-capture and no disturbance of the stream.
  - Sets overrun=1 until rst.
- all_done held high after a stream does not retrigger; it must fall and rise again.
- en=0:
  - All state, counters and done_q are frozen; out_valid is forced to 0.
  - When en returns, the same word is re-presented. No word is skipped or duplicated.
- Buffer capture is a single cycle. final_res may change freely after the capture edge.
- rst mid-stream:
  - Aborts immediately to the reset values.
  - No stream_done is produced and the partial stream is discarded.

Optional Feature:
ATTN_STREAM_CHECKSUM_EN:
- Defined:
  - Adds output port `checksum`, WORD_W bits.
  - Cleared to 0 on capture.
  - XORs in each transferred out_data.
  - Holds the final value from the stream_done pulse until the next capture; reset value 0.
- Undefined: the port and its logic are absent; all other behaviour is identical.

Test Plan:
- Capture and full stream:
  - Stimulus: final_res word i = 16'h3C00+i; one all_done rise; out_ready=1.
  - Response:
    - 32 consecutive transfers, indices 0..31, data 3C00..3C1F.
    - out_last only on index 31.
    - stream_done one cycle after the last transfer.
    - busy low the cycle after that.
- Backpressure:
  - Stimulus: toggle out_ready 1,0,0,1,…
  - Response: each word is held stable while not accepted; all 32 words are delivered exactly once, in order.
- Held all_done / overrun:
  - Stimulus: all_done high for the whole run. Then pulse it low and high during a second stream, at index 10.
  - Response:
    - Only one stream is produced for the held level.
    - The second rise sets overrun=1.
    - Stream data is unchanged.
- en freeze:
  - Stimulus: drop en for 5 cycles while at index 7.
  - Response: out_valid=0 during the freeze; index 7 is re-presented after; total transfers = 32.
- Reset mid-stream:
  - Stimulus: assert rst at index 20.
  - Response: all outputs 0 immediately, with no stream_done. A subsequent rise streams from index 0.
- With ATTN_STREAM_CHECKSUM_EN:
  - Stimulus: the data of scenario 1.
  - Response: checksum = XOR of 3C00..3C1F = 16'h0000 at stream_done. With word 0 replaced by FFFF, expect 16'hC3FF.

Source files
------------

// File: rtl/attn_result_streamer.sv
// attn_result_streamer
//   Drain side of the 8x8 attention array. When all_done rises, the whole
//   final_res vector is copied into a local buffer in one cycle. The buffer is
//   then sent out one word at a time, lowest index first, over a valid/ready
//   handshake.
//
// Ports
//   clk          system clock; all logic runs on its rising edge
//   rst          asynchronous active-high reset
//   en           block enable; 0 freezes all state and masks out_valid
//   all_done     completion level from the array; may stay high indefinitely
//   final_res    result vector; word i = final_res[i*WORD_W +: WORD_W]
//   out_data     current word
//   out_valid    out_data / out_index / out_last are valid
//   out_ready    sink accepts the current word this cycle
//   out_index    index of the current word
//   out_last     high together with index NUM_WORDS-1
//   busy         high while streaming and during the done cycle
//   stream_done  one-cycle pulse after the last transfer
//   overrun      sticky; an all_done rise arrived while not idle
//   checksum     (only with ATTN_STREAM_CHECKSUM_EN) XOR of all words
//                transferred in the current or most recent stream
//
// Optional build macro: ATTN_STREAM_CHECKSUM_EN adds the checksum port.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// S_IDLE   | waiting for an all_done rise; no valid output
// S_STREAM | presenting buffer word out_index until every word is taken
// S_DONE   | single cycle that raises stream_done, then back to idle

module attn_result_streamer #(
  parameter int WORD_W    = 16,
  parameter int NUM_WORDS = 32,
  parameter int IDX_W     = 5
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        en,
  input  logic                        all_done,
  input  logic [WORD_W*NUM_WORDS-1:0] final_res,
  output logic [WORD_W-1:0]           out_data,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [IDX_W-1:0]            out_index,
  output logic                        out_last,
  output logic                        busy,
  output logic                        stream_done,
  output logic                        overrun
`ifdef ATTN_STREAM_CHECKSUM_EN
  ,
  output logic [WORD_W-1:0]           checksum
`endif
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_STREAM,
    S_DONE
  } state_t;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_WORDS - 1);

  state_t                           state_q;
  logic [NUM_WORDS-1:0][WORD_W-1:0] buf_q;
  logic                             done_q;
  logic                             valid_q;
  logic                             rise;
  logic                             xfer;
  logic                             at_last;
  logic [IDX_W-1:0]                 idx_nxt;

  // done_q only advances on enabled cycles, so a rise that lands during a
  // freeze is still seen once en returns.
  assign rise      = en & all_done & ~done_q;
  // Masking with en (rather than clearing valid_q) lets the same word
  // reappear untouched when the freeze ends.
  assign out_valid = valid_q & en;
  assign xfer      = out_valid & out_ready;
  assign at_last   = (out_index == LAST_IDX);
  assign idx_nxt   = out_index + IDX_W'(1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      buf_q       <= '0;
      done_q      <= 1'b0;
      valid_q     <= 1'b0;
      out_data    <= '0;
      out_index   <= '0;
      out_last    <= 1'b0;
      busy        <= 1'b0;
      stream_done <= 1'b0;
      overrun     <= 1'b0;
`ifdef ATTN_STREAM_CHECKSUM_EN
      checksum    <= '0;
`endif
    end else if (en) begin
      done_q <= all_done;
      case (state_q)
        S_IDLE: begin
          if (rise) begin
            buf_q     <= final_res;
            out_index <= '0;
            out_data  <= final_res[WORD_W-1:0];
            out_last  <= (NUM_WORDS == 1);
            valid_q   <= 1'b1;
            busy      <= 1'b1;
            state_q   <= S_STREAM;
`ifdef ATTN_STREAM_CHECKSUM_EN
            checksum  <= '0;
`endif
          end
        end

        S_STREAM: begin
          if (rise) begin
            overrun <= 1'b1;
          end
          if (xfer) begin
`ifdef ATTN_STREAM_CHECKSUM_EN
            checksum <= checksum ^ out_data;
`endif
            if (at_last) begin
              valid_q     <= 1'b0;
              out_last    <= 1'b0;
              stream_done <= 1'b1;
              state_q     <= S_DONE;
            end else begin
              out_index <= idx_nxt;
              out_data  <= buf_q[idx_nxt];
              out_last  <= (idx_nxt == LAST_IDX);
            end
          end
        end

        S_DONE: begin
          if (rise) begin
            overrun <= 1'b1;
          end
          stream_done <= 1'b0;
          busy        <= 1'b0;
          state_q     <= S_IDLE;
        end

        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_attn_result_streamer.sv
module tb_attn_result_streamer;

  localparam int WORD_W    = 16;
  localparam int NUM_WORDS = 32;
  localparam int IDX_W     = 5;

  logic                        clk;
  logic                        rst;
  logic                        en;
  logic                        all_done;
  logic [WORD_W*NUM_WORDS-1:0] final_res;
  logic [WORD_W-1:0]           out_data;
  logic                        out_valid;
  logic                        out_ready;
  logic [IDX_W-1:0]            out_index;
  logic                        out_last;
  logic                        busy;
  logic                        stream_done;
  logic                        overrun;
`ifdef ATTN_STREAM_CHECKSUM_EN
  logic [WORD_W-1:0]           checksum;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  attn_result_streamer #(
    .WORD_W   (WORD_W),
    .NUM_WORDS(NUM_WORDS),
    .IDX_W    (IDX_W)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .all_done   (all_done),
    .final_res  (final_res),
    .out_data   (out_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_index  (out_index),
    .out_last   (out_last),
    .busy       (busy),
    .stream_done(stream_done),
    .overrun    (overrun)
`ifdef ATTN_STREAM_CHECKSUM_EN
    ,
    .checksum   (checksum)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [15:0] exp_word(input int i, input logic [15:0] w0);
    if (i == 0) return w0;
    return 16'h3C00 + 16'(i);
  endfunction

  task automatic load_res(input logic [15:0] w0);
    for (int i = 0; i < NUM_WORDS; i++)
      final_res[i*WORD_W +: WORD_W] = exp_word(i, w0);
  endtask

  // Produce a fresh fall/rise of all_done and check the first word appears.
  task automatic start_capture(input logic [15:0] w0);
    all_done = 1'b0;
    step();
    all_done = 1'b1;
    step();
    check("cap_valid", out_valid, 1);
    check("cap_index", out_index, 0);
    check("cap_data", out_data, w0);
    check("cap_busy", busy, 1);
  endtask

  // Drain one stream. mode 0: ready always high; mode 1: ready 1,0,0,...
  // freeze_at / pulse_at / abort_at: index at which to drop en, pulse
  // all_done, or assert rst (-1 to disable).
  task automatic run_stream(input int mode, input int freeze_at, input int pulse_at,
                            input int abort_at, input logic [15:0] w0,
                            input logic [15:0] exp_sum);
    int exp_idx;
    int cyc;
    int pulse;
    bit frozen;
    bit have_prev;
    logic [15:0] prev_data;
    logic [IDX_W-1:0] prev_idx;
    exp_idx = 0;
    cyc = 0;
    pulse = 0;
    frozen = 0;
    have_prev = 0;
    prev_data = '0;
    prev_idx = '0;
    while (exp_idx < NUM_WORDS && cyc < 600) begin
      if (abort_at == exp_idx) begin
        rst = 1'b1;
        #1;
        check("rst_valid", out_valid, 0);
        check("rst_data", out_data, 0);
        check("rst_index", out_index, 0);
        check("rst_last", out_last, 0);
        check("rst_busy", busy, 0);
        check("rst_done", stream_done, 0);
        check("rst_overrun", overrun, 0);
        return;
      end
      if (freeze_at == exp_idx && !frozen) begin
        frozen = 1;
        out_ready = 1'b1;
        en = 1'b0;
        #1;
        repeat (5) begin
          check("frz_valid", out_valid, 0);
          check("frz_index", out_index, 7'(freeze_at));
          step();
        end
        en = 1'b1;
        #1;
        check("frz_repres", out_index, 7'(freeze_at));
      end
      if (pulse_at == exp_idx && pulse == 0) begin
        all_done = 1'b0;
        final_res = {NUM_WORDS{16'hA5A5}};
        pulse = 1;
      end else if (pulse == 1) begin
        all_done = 1'b1;
        pulse = 2;
      end
      out_ready = (mode == 0) ? 1'b1 : (cyc % 3 == 0);
      check("stream_valid", out_valid, 1);
      if (out_valid) begin
        if (have_prev) begin
          check("hold_data", out_data, prev_data);
          check("hold_index", out_index, prev_idx);
        end
        if (out_ready) begin
          check("xfer_index", out_index, exp_idx);
          check("xfer_data", out_data, exp_word(exp_idx, w0));
          check("xfer_last", out_last, (exp_idx == NUM_WORDS - 1));
          exp_idx++;
          have_prev = 0;
        end else begin
          have_prev = 1;
          prev_data = out_data;
          prev_idx = out_index;
        end
      end
      step();
      cyc++;
    end
    check("stream_count", exp_idx, NUM_WORDS);
    check("done_pulse", stream_done, 1);
    check("done_busy", busy, 1);
    check("done_valid", out_valid, 0);
    check("done_last", out_last, 0);
`ifdef ATTN_STREAM_CHECKSUM_EN
    check("checksum", checksum, exp_sum);
`else
    if (exp_sum != exp_sum + 16'd1) n_tests += 0;
`endif
    step();
    check("after_done", stream_done, 0);
    check("after_busy", busy, 0);
  endtask

  initial begin
    rst = 1'b1;
    en = 1'b1;
    all_done = 1'b0;
    out_ready = 1'b0;
    load_res(16'h3C00);
    step();
    step();
    check("reset_valid", out_valid, 0);
    check("reset_data", out_data, 0);
    check("reset_index", out_index, 0);
    check("reset_last", out_last, 0);
    check("reset_busy", busy, 0);
    check("reset_done", stream_done, 0);
    check("reset_overrun", overrun, 0);
    rst = 1'b0;
    step();

    // Full stream; all_done then stays high afterwards.
    out_ready = 1'b1;
    start_capture(16'h3C00);
    run_stream(0, -1, -1, -1, 16'h3C00, 16'h0000);
    repeat (10) step();
    check("held_no_retrig_valid", out_valid, 0);
    check("held_no_retrig_busy", busy, 0);
    check("held_overrun_clear", overrun, 0);

    // Second stream with an all_done pulse (and final_res change) at index 10.
    start_capture(16'h3C00);
    run_stream(0, -1, 10, -1, 16'h3C00, 16'h0000);
    check("overrun_set", overrun, 1);
    load_res(16'hFFFF);

    // Backpressure with word 0 = FFFF.
    start_capture(16'hFFFF);
    run_stream(1, -1, -1, -1, 16'hFFFF, 16'hC3FF);
    check("overrun_sticky", overrun, 1);
    load_res(16'h3C00);

    // en freeze at index 7.
    start_capture(16'h3C00);
    run_stream(0, 7, -1, -1, 16'h3C00, 16'h0000);

    // Reset at index 20, then a clean stream from index 0.
    start_capture(16'h3C00);
    run_stream(0, -1, -1, 20, 16'h3C00, 16'h0000);
    all_done = 1'b0;
    step();
    step();
    rst = 1'b0;
    repeat (3) begin
      step();
      check("post_rst_no_done", stream_done, 0);
      check("post_rst_idle", out_valid, 0);
    end
    start_capture(16'h3C00);
    run_stream(0, -1, -1, -1, 16'h3C00, 16'h0000);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
